// File: rtl/ffd_univ_reg.sv
// Universal D flip-flop register: hold, load, shift left/right, serial chaining.
// Optional rotate in the shift modes when FFD_ROTATE_EN is defined.
//
// Parameters:
//   WIDTH   : register width in bits (2..32)
//   RST_VAL : value forced onto Q while RST is high
//
// Ports:
//   CLK  : rising-edge clock
//   RST  : asynchronous reset, active-high
//   EN   : clock enable (CLR still acts when EN=0)
//   CLR  : synchronous clear to zero, overrides EN/MODE
//   MODE : 00 hold, 01 load D, 10 shift left, 11 shift right
//   D    : parallel load data
//   SIL  : serial in for shift left, enters at bit 0
//   SIR  : serial in for shift right, enters at bit WIDTH-1
//   ROT  : rotate select in shift modes (FFD_ROTATE_EN builds only)
//   Q    : registered state
//   SOL  : serial out left  = Q[WIDTH-1]
//   SOR  : serial out right = Q[0]
module ffd_univ_reg #(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    input  logic             ROT,
    output logic [WIDTH-1:0] Q,
    output logic             SOL,
    output logic             SOR
);

    typedef enum logic [1:0] {
        M_HOLD = 2'b00,
        M_LOAD = 2'b01,
        M_SHL  = 2'b10,
        M_SHR  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             shl_in;
    logic             shr_in;

    // Bit entering the vacated position of each shift direction.
`ifdef FFD_ROTATE_EN
    assign shl_in = ROT ? q_q[WIDTH-1] : SIL;
    assign shr_in = ROT ? q_q[0]       : SIR;
`else
    logic unused_rot;
    assign unused_rot = ROT;
    assign shl_in     = SIL;
    assign shr_in     = SIR;
`endif

    always_comb begin
        q_d = q_q;
        if (CLR) begin
            q_d = '0;
        end else if (EN) begin
            case (mode_e'(MODE))
                M_HOLD:  q_d = q_q;
                M_LOAD:  q_d = D;
                M_SHL:   q_d = {q_q[WIDTH-2:0], shl_in};
                M_SHR:   q_d = {shr_in, q_q[WIDTH-1:1]};
                default: q_d = 'x;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Serial outputs come from the registered state only, so chained
    // stages all see pre-edge values and update without a race.
    assign Q   = q_q;
    assign SOL = q_q[WIDTH-1];
    assign SOR = q_q[0];

endmodule
